// File: rtl/fpu_add_arbiter.sv
// Round-robin arbiter that serialises N_REQ requesters onto one handshaked FP adder,
// with a single operation in flight from grant through response.
module fpu_add_arbiter #(
  parameter int N_REQ = 4,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [32*N_REQ-1:0] req_a,
  input  logic [32*N_REQ-1:0] req_b,
  output logic [N_REQ-1:0]    req_ready,
  output logic [N_REQ-1:0]    rsp_valid,
  output logic [31:0]         rsp_z,
  input  logic [N_REQ-1:0]    rsp_ready,
  output logic                add_start,
  output logic [31:0]         add_a,
  output logic [31:0]         add_b,
  output logic                add_a_stb,
  output logic                add_b_stb,
  input  logic                add_a_ack,
  input  logic                add_b_ack,
  input  logic [31:0]         add_z,
  input  logic                add_z_stb,
  output logic                add_ack_output,
  input  logic                add_idle,
  input  logic                add_valid,
  output logic [CNT_W-1:0]    op_count
);
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {
    IDLE, START, SEND_A, SEND_B, WAIT_Z, WAIT_VALID, RESPOND
  } state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] rr_ptr, grant, grant_scan, rr_nxt;
  logic             found;
  logic [31:0]      op_a, op_b;
  logic             accept, a_load, b_load, z_take, rsp_done;

  // Scan requesters starting at rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    int idx;
    found      = 1'b0;
    grant_scan = '0;
    idx        = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req_valid[IDX_W'(idx)]) begin
        found      = 1'b1;
        grant_scan = IDX_W'(idx);
      end
    end
  end

  assign rr_nxt   = (grant_scan == IDX_W'(N_REQ - 1)) ? '0 : grant_scan + 1'b1;
  assign accept   = (state == IDLE) && found;
  assign a_load   = (state == START) && add_idle;
  assign b_load   = (state == SEND_A) && add_a_ack;
  assign z_take   = (state == WAIT_Z) && add_z_stb;
  assign rsp_done = (state == RESPOND) && rsp_ready[grant];

  always_comb begin
    state_nxt      = state;
    req_ready      = '0;
    rsp_valid      = '0;
    add_start      = 1'b0;
    add_a_stb      = 1'b0;
    add_b_stb      = 1'b0;
    add_ack_output = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          req_ready[grant_scan] = 1'b1;
          state_nxt             = START;
        end
      end
      START: begin
        if (add_idle) begin
          add_start = 1'b1;
          state_nxt = SEND_A;
        end
      end
      SEND_A: begin
        add_a_stb = 1'b1;
        if (add_a_ack) state_nxt = SEND_B;
      end
      SEND_B: begin
        add_b_stb = 1'b1;
        if (add_b_ack) state_nxt = WAIT_Z;
      end
      WAIT_Z: begin
        add_ack_output = 1'b1;
        if (add_z_stb) state_nxt = WAIT_VALID;
      end
      WAIT_VALID: begin
        add_ack_output = 1'b1;
        if (add_valid) state_nxt = RESPOND;
      end
      RESPOND: begin
        rsp_valid[grant] = 1'b1;
        if (rsp_ready[grant]) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control state; adder operands are loaded just before their strobe so they hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant    <= '0;
      op_count <= '0;
      add_a    <= '0;
      add_b    <= '0;
      rsp_z    <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        grant  <= grant_scan;
        rr_ptr <= rr_nxt;
      end
      if (a_load)   add_a    <= op_a;
      if (b_load)   add_b    <= op_b;
      if (z_take)   rsp_z    <= add_z;
      if (rsp_done) op_count <= op_count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      op_a <= req_a[32*grant_scan +: 32];
      op_b <= req_b[32*grant_scan +: 32];
    end
  end

endmodule

// File: tb/tb_fpu_add_arbiter.sv
// Directed bench for fpu_add_arbiter: table-driven adder model, scoreboard of expected
// responses, and a monitor that checks every response handshake.
`timescale 1ns/1ps
module tb_fpu_add_arbiter;
  localparam int N_REQ = 4;
  localparam int CNT_W = 16;

  logic               clk;
  logic               rst;
  logic [N_REQ-1:0]   req_valid;
  logic [32*N_REQ-1:0] req_a;
  logic [32*N_REQ-1:0] req_b;
  logic [N_REQ-1:0]   req_ready;
  logic [N_REQ-1:0]   rsp_valid;
  logic [31:0]        rsp_z;
  logic [N_REQ-1:0]   rsp_ready;
  logic               add_start;
  logic [31:0]        add_a;
  logic [31:0]        add_b;
  logic               add_a_stb;
  logic               add_b_stb;
  logic               add_a_ack;
  logic               add_b_ack;
  logic [31:0]        add_z;
  logic               add_z_stb;
  logic               add_ack_output;
  logic               add_idle;
  logic               add_valid;
  logic [CNT_W-1:0]   op_count;

  logic a_ack_en, b_ack_en, idle_hold, glitch;
  int   phase, dly;
  logic [31:0] cap_a, cap_b;

  typedef struct {
    int          idx;
    logic [31:0] z;
  } exp_t;
  exp_t sb[$];

  int checks   = 0;
  int failures = 0;

  fpu_add_arbiter #(.N_REQ(N_REQ), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_z(rsp_z), .rsp_ready(rsp_ready),
    .add_start(add_start), .add_a(add_a), .add_b(add_b),
    .add_a_stb(add_a_stb), .add_b_stb(add_b_stb),
    .add_a_ack(add_a_ack), .add_b_ack(add_b_ack),
    .add_z(add_z), .add_z_stb(add_z_stb), .add_ack_output(add_ack_output),
    .add_idle(add_idle), .add_valid(add_valid), .op_count(op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign add_a_ack = add_a_stb & a_ack_en;
  assign add_b_ack = add_b_stb & b_ack_en;
  assign add_idle  = (phase == 0) && !idle_hold;

  function automatic logic [31:0] lookup(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h3F800000, 32'h40000000}: return 32'h40400000; // 1+2=3
      {32'h3F800000, 32'h3F800000}: return 32'h40000000; // 1+1=2
      {32'h40000000, 32'h40000000}: return 32'h40800000; // 2+2=4
      {32'h40800000, 32'h3F800000}: return 32'h40A00000; // 4+1=5
      {32'h40400000, 32'h40400000}: return 32'h40C00000; // 3+3=6
      {32'h40A00000, 32'hC0A00000}: return 32'h00000000; // 5-5=0
      default:                      return 32'hDEADBEEF;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
  endtask

  task automatic push(input int i, input logic [31:0] z);
    exp_t e;
    e.idx = i;
    e.z   = z;
    sb.push_back(e);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rsp_z"}, rsp_z, 32'd0);
    check({tag, "_add_start"}, 32'(add_start), 32'd0);
    check({tag, "_stbs"}, 32'({add_a_stb, add_b_stb, add_ack_output}), 32'd0);
    check({tag, "_add_a"}, add_a, 32'd0);
    check({tag, "_add_b"}, add_b, 32'd0);
    check({tag, "_op_count"}, 32'(op_count), 32'd0);
  endtask

  // Hold mask on req_valid until nacc accepts; optionally drop each requester once granted.
  task automatic run_set(input logic [3:0] mask, input int nacc, input bit drop_each);
    int got, cyc;
    logic [3:0] seen;
    got = 0;
    cyc = 0;
    step();
    req_valid = mask;
    while (got < nacc && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (req_ready != '0) begin
        seen = req_ready;
        check("grant_onehot_in_mask", 32'($onehot(seen) && ((seen & ~mask) == 4'b0)), 32'd1);
        got++;
        step();
        if (drop_each) req_valid = req_valid & ~seen;
      end
    end
    check("accept_timeout", 32'(got == nacc), 32'd1);
    req_valid = '0;
  endtask

  task automatic drain(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk);
      if (sb.size() == 0) ok = 1'b1;
    end
    check(name, 32'(ok), 32'd1);
    step();
  endtask

  // Adder model: acks combinationally, answers from the hand-computed table after a delay.
  initial begin : adder_model
    phase = 0; dly = 0; cap_a = '0; cap_b = '0;
    add_z_stb = 1'b0; add_valid = 1'b0; add_z = '0;
    forever begin
      @(posedge clk);
      #2;
      add_z_stb = 1'b0;
      add_valid = 1'b0;
      if (rst) begin
        phase = 0;
      end else begin
        case (phase)
          0: begin
            if (add_a_stb && add_a_ack) cap_a = add_a;
            if (add_b_stb && add_b_ack) begin
              cap_b = add_b;
              dly   = 3;
              phase = 1;
            end
          end
          1: begin
            if (dly > 0) dly--;
            else begin
              add_z     = lookup(cap_a, cap_b);
              add_z_stb = 1'b1;
              phase     = 2;
            end
          end
          default: begin
            add_valid = 1'b1;
            phase     = 0;
          end
        endcase
        if (glitch && phase == 0) begin
          add_z_stb = 1'b1;
          add_valid = 1'b1;
          add_z     = 32'hBAD0BAD0;
        end
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && rsp_valid != '0) begin
        check("rsp_no_grant", 32'(req_ready), 32'd0);
        if ((rsp_valid & rsp_ready) != '0) begin
          if (sb.size() == 0) check("rsp_unexpected", 32'(rsp_valid), 32'd0);
          else begin
            e = sb.pop_front();
            check("rsp_valid_idx", 32'(rsp_valid), 32'd1 << e.idx);
            check("rsp_z", rsp_z, e.z);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    bit ok;
    int lat;
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = '1;
    a_ack_en = 1'b1; b_ack_en = 1'b1; idle_hold = 1'b0; glitch = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("por");
    step();
    rst = 1'b0;

    // Single operation 1.0 + 2.0
    set_op(0, 32'h3F800000, 32'h40000000);
    push(0, 32'h40400000);
    run_set(4'b0001, 1, 1'b0);
    drain("single_drain");
    check("single_op_count", 32'(op_count), 32'd1);

    // Fresh reset so rr_ptr restarts at 0
    rst = 1'b1;
    @(negedge clk);
    check("rst2_op_count", 32'(op_count), 32'd0);
    step();
    rst = 1'b0;

    // Round robin with all requesters held: 0,1,2,3,0
    for (int i = 0; i < 4; i++) set_op(i, 32'h3F800000, 32'h3F800000);
    push(0, 32'h40000000); push(1, 32'h40000000); push(2, 32'h40000000);
    push(3, 32'h40000000); push(0, 32'h40000000);
    run_set(4'b1111, 5, 1'b0);
    drain("rr_drain");
    check("rr_op_count", 32'(op_count), 32'd5);

    // rr_ptr=1 with requesters 0 and 3: scan 1,2,3 picks 3 before 0
    set_op(3, 32'h40800000, 32'h3F800000);
    set_op(0, 32'h3F800000, 32'h40000000);
    push(3, 32'h40A00000); push(0, 32'h40400000);
    run_set(4'b1001, 2, 1'b1);
    drain("order_drain");
    set_op(1, 32'h40000000, 32'h40000000);
    push(1, 32'h40800000);
    run_set(4'b0010, 1, 1'b1);
    drain("slice1_drain");
    check("order_op_count", 32'(op_count), 32'd8);

    // Backpressure on requester 2, with adder glitches and a waiting requester 0
    set_op(2, 32'h40400000, 32'h40400000);
    set_op(0, 32'h40A00000, 32'hC0A00000);
    rsp_ready[2] = 1'b0;
    push(2, 32'h40C00000);
    run_set(4'b0100, 1, 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (rsp_valid[2]) ok = 1'b1;
    end
    check("bp_rsp_seen", 32'(ok), 32'd1);
    step();
    req_valid[0] = 1'b1;
    glitch = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_rsp_valid", 32'(rsp_valid), 32'h4);
      check("bp_rsp_z", rsp_z, 32'h40C00000);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      check("bp_add_start", 32'(add_start), 32'd0);
    end
    step();
    glitch = 1'b0;
    push(0, 32'h00000000);
    rsp_ready[2] = 1'b1;
    run_set(4'b0001, 1, 1'b1);
    drain("cancel_drain");
    check("bp_op_count", 32'(op_count), 32'd10);

    // Reset while stalled in SEND_B abandons the operation
    set_op(1, 32'h3F800000, 32'h3F800000);
    b_ack_en = 1'b0;
    run_set(4'b0010, 1, 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (add_b_stb) ok = 1'b1;
    end
    check("sendb_reached", 32'(ok), 32'd1);
    rst = 1'b1;
    #1;
    check_reset_vals("midop");
    step();
    rst = 1'b0;
    b_ack_en = 1'b1;
    set_op(0, 32'h3F800000, 32'h3F800000);
    set_op(2, 32'h3F800000, 32'h3F800000);
    push(0, 32'h40000000); push(2, 32'h40000000);
    run_set(4'b0101, 2, 1'b1);
    drain("post_rst_drain");
    check("post_rst_op_count", 32'(op_count), 32'd2);

    // Adder busy for 20 cycles after accept: start must wait for add_idle
    idle_hold = 1'b1;
    set_op(3, 32'h3F800000, 32'h40000000);
    push(3, 32'h40400000);
    run_set(4'b1000, 1, 1'b1);
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (add_start) ok = 1'b0;
    end
    check("idle_hold_no_start", 32'(ok), 32'd1);
    step();
    idle_hold = 1'b0;
    lat = -1;
    for (int i = 0; i < 3 && lat < 0; i++) begin
      @(negedge clk);
      if (add_start) lat = i;
    end
    check("start_after_idle", 32'(lat >= 0 && lat <= 1), 32'd1);
    @(negedge clk);
    check("start_one_cycle", 32'(add_start), 32'd0);
    drain("idle_drain");
    check("idle_op_count", 32'(op_count), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
